noc_xy_router: RTL and testbench

- Parametrised 5-port mesh router: Local, West, East, North, South.
- Successor to the fixed 18-bit router; generalises flit width, coordinate width and buffer depth.
- Adds per-input FIFOs, valid/ready backpressure, XY dimension-order routing and per-output round-robin arbitration.
- Instantiated once per mesh node by a generated mesh top; its own coordinates are supplied as static inputs.

---
 rtl/noc_pkg.sv | 33 +++
 rtl/noc_fifo.sv | 50 +++++
 rtl/noc_xy_router.sv | 114 +++++++++++
 tb/tb_noc_xy_router.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared port numbering, flit field positions and the XY routing rule for the mesh router.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;

  typedef logic [2:0] port_idx_t;

  localparam port_idx_t PORT_L = 3'd0;
  localparam port_idx_t PORT_W = 3'd1;
  localparam port_idx_t PORT_E = 3'd2;
  localparam port_idx_t PORT_N = 3'd3;
  localparam port_idx_t PORT_S = 3'd4;

  // Destination X occupies the top bits of the flit, destination Y sits just below it.
  function automatic int unsigned dest_x_msb(input int unsigned flit_w);
    return flit_w - 1;
  endfunction

  function automatic int unsigned dest_y_msb(input int unsigned flit_w, input int unsigned x_w);
    return flit_w - 1 - x_w;
  endfunction

  // Dimension-order routing: resolve X first, then Y (Y grows southward).
  function automatic port_idx_t xy_route(input int unsigned dest_x, input int unsigned dest_y,
                                         input int unsigned cur_x, input int unsigned cur_y);
    if (dest_x > cur_x) return PORT_E;
    if (dest_x < cur_x) return PORT_W;
    if (dest_y > cur_y) return PORT_S;
    if (dest_y < cur_y) return PORT_N;
    return PORT_L;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Per-input flit FIFO with registered occupancy count; full/empty derive from the count.
module noc_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/noc_xy_router.sv
// Five-port mesh router: input FIFOs, XY routing, per-output round-robin and output registers.
module noc_xy_router
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W     = 18,
  parameter int unsigned X_W        = 2,
  parameter int unsigned Y_W        = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [X_W-1:0]                cur_x,
  input  logic [Y_W-1:0]                cur_y,
  input  logic [NUM_PORTS*FLIT_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS*FLIT_W-1:0]   out_data,
  output logic [NUM_PORTS-1:0]          out_valid,
  input  logic [NUM_PORTS-1:0]          out_ready
);

  localparam int unsigned DxMsb = dest_x_msb(FLIT_W);
  localparam int unsigned DyMsb = dest_y_msb(FLIT_W, X_W);

  logic [NUM_PORTS-1:0]                 full, empty, push, pop;
  logic [NUM_PORTS-1:0][FLIT_W-1:0]     head;
  port_idx_t                            route [NUM_PORTS];
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  gnt;  // gnt[output][input]

  assign in_ready = ~full & {NUM_PORTS{rst}};
  assign push     = in_valid & in_ready;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    noc_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push[i]),
      .data_i  (in_data[i*FLIT_W +: FLIT_W]),
      .pop_i   (pop[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .head_o  (head[i])
    );

    assign route[i] = xy_route(32'(head[i][DxMsb -: X_W]), 32'(head[i][DyMsb -: Y_W]),
                               32'(cur_x), 32'(cur_y));
  end

  // Each head requests a single output, so OR-ing the grant columns never double-pops.
  always_comb begin
    pop = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      pop = pop | gnt[o];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0] req, grant;
    port_idx_t            rr_q, rr_d, win, idx;
    logic                 can_load, found;
    logic                 valid_q;
    logic [FLIT_W-1:0]    data_q, data_d;

    always_comb begin
      req = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        req[i] = ~empty[i] & (route[i] == port_idx_t'(o));
      end
    end

    // Loading is allowed into an empty register or one being drained this cycle.
    assign can_load = ~valid_q | out_ready[o];

    always_comb begin
      grant = '0;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = port_idx_t'((32'(rr_q) + k) % NUM_PORTS);
        if (!found && can_load && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
          win        = idx;
        end
      end
    end

    assign rr_d   = (win == port_idx_t'(NUM_PORTS - 1)) ? '0 : win + 3'd1;
    assign data_d = head[win];
    assign gnt[o] = grant;

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        rr_q    <= '0;
      end else if (found) begin
        valid_q <= 1'b1;
        data_q  <= data_d;
        rr_q    <= rr_d;
      end else if (out_ready[o]) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid[o]                  = valid_q;
    assign out_data[o*FLIT_W +: FLIT_W]  = data_q;
  end

endmodule

// File: tb/tb_noc_xy_router.sv
// Bench for noc_xy_router: routing vector table, fairness/backpressure/reset sequences, random
// traffic scored per (source, output) against an ordered-queue model.
module tb_noc_xy_router;

  localparam int FW = 18;
  localparam int NP = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      cur_x, cur_y;
  logic [NP*FW-1:0] in_data, out_data;
  logic [NP-1:0]   in_valid, in_ready, out_valid, out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  noc_xy_router #(
    .FLIT_W     (FW),
    .X_W        (2),
    .Y_W        (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [1:0]  cx;
    logic [1:0]  cy;
    int          port;
    logic [1:0]  dx;
    logic [1:0]  dy;
    logic [13:0] pay;
    int          exp_port;
  } vec_t;

  vec_t vecs [7];

  // Pending flits per (source port, output port), in arrival order.
  logic [FW-1:0] sb [NP*NP][$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk_flit(input logic [1:0] dx, input logic [1:0] dy,
                                           input logic [13:0] pay);
    return {dx, dy, pay};
  endfunction

  function automatic logic [FW-1:0] out_flit(input int p);
    return out_data[p*FW +: FW];
  endfunction

  task automatic set_in(input int p, input logic [FW-1:0] f);
    in_data[p*FW +: FW] = f;
    in_valid[p] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = '0;
    in_data = '0;
    tick();
    rst = 1'b1;
  endtask

  function automatic int model_route(input int dx, input int dy, input int cx, input int cy);
    if (dx > cx) return 2;
    if (dx < cx) return 1;
    if (dy > cy) return 4;
    if (dy < cy) return 3;
    return 0;
  endfunction

  task automatic score_outputs();
    for (int o = 0; o < NP; o++) begin
      if (out_valid[o] && out_ready[o]) begin
        logic [FW-1:0] f;
        int src;
        f = out_flit(o);
        src = int'(f[13:11]);
        if (src < NP && sb[src*NP+o].size() > 0) begin
          check("rand_flit", f, sb[src*NP+o].pop_front());
        end else begin
          n_checks++;
          $display("FAIL rand_unexpected: port %0d got %h with nothing pending", o, f);
        end
      end
    end
  endtask

  initial begin
    logic [NP*FW-1:0] exp_bus;
    logic [FW-1:0] f;
    logic [FW-1:0] rr_w [2], rr_n [2], rr_s [2], rr_exp [6];
    logic [FW-1:0] bp_f [6], got [$];
    logic [FW-1:0] s_f [20];
    logic [FW-1:0] offer [NP];
    logic [1:0] odx [NP], ody [NP];
    int acc, stale, left;
    logic [10:0] seq;

    vecs[0] = '{2'd1, 2'd1, 0, 2'd3, 2'd3, 14'h0123, 2};
    vecs[1] = '{2'd1, 2'd1, 1, 2'd1, 2'd0, 14'h00ab, 3};
    vecs[2] = '{2'd1, 2'd1, 4, 2'd1, 2'd1, 14'h0155, 0};
    vecs[3] = '{2'd1, 2'd1, 3, 2'd0, 2'd3, 14'h002a, 1};
    vecs[4] = '{2'd2, 2'd0, 0, 2'd2, 2'd2, 14'h0003, 4};
    vecs[5] = '{2'd0, 2'd0, 2, 2'd0, 2'd0, 14'h0077, 0};
    vecs[6] = '{2'd3, 2'd3, 0, 2'd0, 2'd0, 14'h0011, 1};

    rst = 1'b0;
    cur_x = 2'd1;
    cur_y = 2'd1;
    in_data = '0;
    in_valid = '0;
    out_ready = '0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready_low", in_ready, 5'b00000);
    check("rst_out_valid", out_valid, 5'b00000);
    check("rst_out_data", out_data, '0);
    rst = 1'b1;
    #1;
    check("rst_in_ready_high", in_ready, 5'b11111);

    // Routing table: one flit, two-cycle latency, exactly one output lit
    for (int v = 0; v < 7; v++) begin
      cur_x = vecs[v].cx;
      cur_y = vecs[v].cy;
      do_reset();
      out_ready = '1;
      f = mk_flit(vecs[v].dx, vecs[v].dy, vecs[v].pay);
      set_in(vecs[v].port, f);
      tick();
      in_valid = '0;
      check("route_latency", out_valid, 5'b00000);
      tick();
      check("route_valid", out_valid, 5'b00001 << vecs[v].exp_port);
      exp_bus = '0;
      exp_bus[vecs[v].exp_port*FW +: FW] = f;
      check("route_data", out_data, exp_bus);
      if (v == 0) check("route_first_flit", out_flit(2), 18'h3C123);
    end

    // Fairness: W, N, S all target E; two rounds come out W, N, S, W, N, S
    cur_x = 2'd1;
    cur_y = 2'd1;
    do_reset();
    out_ready = '1;
    for (int k = 0; k < 2; k++) begin
      rr_w[k] = mk_flit(2'd3, 2'd1, 14'h0101 + 14'(k));
      rr_n[k] = mk_flit(2'd3, 2'd1, 14'h0301 + 14'(k));
      rr_s[k] = mk_flit(2'd3, 2'd1, 14'h0401 + 14'(k));
      rr_exp[3*k]   = rr_w[k];
      rr_exp[3*k+1] = rr_n[k];
      rr_exp[3*k+2] = rr_s[k];
    end
    for (int k = 0; k < 2; k++) begin
      set_in(1, rr_w[k]);
      set_in(3, rr_n[k]);
      set_in(4, rr_s[k]);
      tick();
    end
    in_valid = '0;
    for (int k = 0; k < 6; k++) begin
      check("rr_order", {out_valid[2], out_flit(2)}, {1'b1, rr_exp[k]});
      tick();
    end

    // Backpressure: E stalled, six flits offered on L
    do_reset();
    out_ready = 5'b11011;
    for (int k = 0; k < 6; k++) bp_f[k] = mk_flit(2'd3, 2'd2, 14'h0a00 + 14'(k));
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = '0;
      if (acc < 6) set_in(0, bp_f[acc]);
      #1;
      if (in_valid[0] && in_ready[0]) acc++;
      tick();
    end
    check("bp_accepted", acc, 5);
    check("bp_in_ready_low", in_ready[0], 1'b0);
    check("bp_held", {out_valid[2], out_flit(2)}, {1'b1, bp_f[0]});
    tick();
    tick();
    check("bp_held_stable", {out_valid[2], out_flit(2)}, {1'b1, bp_f[0]});
    out_ready = '1;
    got.delete();
    for (int c = 0; c < 30; c++) begin
      in_valid = '0;
      if (acc < 6) set_in(0, bp_f[acc]);
      #1;
      if (in_valid[0] && in_ready[0]) acc++;
      if (out_valid[2] && out_ready[2]) got.push_back(out_flit(2));
      tick();
    end
    check("bp_delivered", got.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < got.size()) check("bp_order", got[k], bp_f[k]);
      else check("bp_order_missing", k, got.size());
    end

    // Sustained push+pop on L toward E: one flit per cycle through the wrapping FIFO
    do_reset();
    out_ready = '1;
    for (int k = 0; k < 20; k++) s_f[k] = mk_flit(2'd2, 2'd1, 14'h1000 + 14'(k));
    for (int c = 0; c < 22; c++) begin
      in_valid = '0;
      if (c < 20) set_in(0, s_f[c]);
      #1;
      if (c < 20) check("thru_ready", in_ready[0], 1'b1);
      if (c >= 2) check("thru_flit", {out_valid[2], out_flit(2)}, {1'b1, s_f[c-2]});
      tick();
    end
    in_valid = '0;

    // Reset mid-stream under saturation
    do_reset();
    for (int c = 0; c < 12; c++) begin
      for (int p = 0; p < NP; p++) begin
        set_in(p, mk_flit(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 14'($urandom)));
      end
      out_ready = 5'($urandom);
      tick();
    end
    rst = 1'b0;
    #1;
    check("midrst_in_ready_low", in_ready, 5'b00000);
    tick();
    check("midrst_out_valid", out_valid, 5'b00000);
    check("midrst_out_data", out_data, '0);
    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    #1;
    check("midrst_in_ready_high", in_ready, 5'b11111);
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid != '0) stale++;
      tick();
    end
    check("midrst_no_stale", stale, 0);

    // Random traffic against the ordered-queue scoreboard
    cur_x = 2'd2;
    cur_y = 2'd1;
    do_reset();
    seq = '0;
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) != 0) begin
          odx[p] = 2'($urandom_range(0, 3));
          ody[p] = 2'($urandom_range(0, 3));
          offer[p] = mk_flit(odx[p], ody[p], {3'(p), seq});
          seq++;
          set_in(p, offer[p]);
        end else begin
          in_valid[p] = 1'b0;
        end
      end
      for (int o = 0; o < NP; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (in_valid[p] && in_ready[p]) begin
          sb[p*NP + model_route(int'(odx[p]), int'(ody[p]), int'(cur_x), int'(cur_y))]
            .push_back(offer[p]);
        end
      end
      score_outputs();
      tick();
    end
    in_valid = '0;
    out_ready = '1;
    for (int c = 0; c < 40; c++) begin
      #1;
      score_outputs();
      tick();
    end
    left = 0;
    for (int k = 0; k < NP*NP; k++) left += sb[k].size();
    check("rand_drained", left, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
